// File: rtl/abs_arbiter_if.sv
// abs_arbiter_if: requester operand handshake and response bundle for abs_arbiter
interface abs_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WIDTH-1:0]       resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_ovf;
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_ovf
  );
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_ovf
  );
endinterface

// File: rtl/abs_arbiter.sv
// abs_arbiter: round-robin scheduler sharing one multi-cycle absolute-value datapath
module abs_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 4,
  parameter int ID_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  abs_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] abs_in,
  input  logic [WIDTH-1:0] abs_out,
  output logic             busy
);
  localparam int cnt_w = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int pw = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;
  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             resp_ovf_q, resp_ovf_d;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [pw-1:0]    idx;
  logic             grant;
  // first valid requester searching upward from ptr+1, wrapping mod N_REQ
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = pw'((int'(ptr_q) + k) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end
  assign grant = rst_n && state_q == S_IDLE && found;
  assign bus.req_ready = grant ? N_REQ'(1) << winner : '0;
  assign abs_in = op_q;
  assign busy = state_q != S_IDLE;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_id = resp_id_q;
  assign bus.resp_ovf = resp_ovf_q;
  // next-state: accept in IDLE, hold operand through the settle window, present until taken
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    op_d = op_q;
    cnt_d = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d = resp_data_q;
    resp_id_d = resp_id_q;
    resp_ovf_d = resp_ovf_q;
    case (state_q)
      S_IDLE: if (grant) begin
        op_d = WIDTH'(bus.req_data >> (int'(winner) * WIDTH));
        id_d = winner;
        ptr_d = winner;
        cnt_d = cnt_w'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        resp_data_d = abs_out;
        resp_ovf_d = op_q == min_neg;
        resp_id_d = id_q;
        resp_valid_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state register; reset restarts the search at requester 0 and drops any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q <= '0;
      resp_id_q <= '0;
      resp_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q <= resp_data_d;
      resp_id_q <= resp_id_d;
      resp_ovf_q <= resp_ovf_d;
    end
  end
endmodule
